// File: rtl/dac_pkg.sv
// Shared types and DAC7611 defaults for the 3-wire serial DAC driver.
// Holds the frame FSM state enum and the idle pin levels.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int DAC7611_DATA_W = 12;
    localparam int DAC7611_DIV    = 2;
    localparam int DAC7611_GAP    = 150;

    localparam logic SCLK_IDLE = 1'b1;
    localparam logic LD_IDLE   = 1'b0;

endpackage

// File: rtl/dac_tick_div.sv
// Free-running down-counter giving a one-cycle tick every DIV cycles.
// Ports: clk_X4, rst_n, load_i (restart period), tick_o (this cycle ends
// a period), pre_tick_o (next cycle ends a period).
module dac_tick_div #(
    parameter int DIV = 2
) (
    input  logic clk_X4,
    input  logic rst_n,
    input  logic load_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (load_i || cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk_X4 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o     = (cnt_q == '0);
    assign pre_tick_o = (cnt_d == '0);

endmodule

// File: rtl/dac_serial_tx.sv
// Serial driver for DAC7611-class DACs: accepts a word on valid/ready and
// emits SETUP / SHIFT (MSB first) / HOLD / GAP on SCLK, SDI and LD.
// Ports: clk_X4, rst_n, enable, s_valid/s_data/s_ready (word input),
// dac_sclk/dac_sdi/dac_ld (pins), busy, done (end-of-HOLD pulse).
module dac_serial_tx
    import dac_pkg::*;
#(
    parameter int DATA_W  = DAC7611_DATA_W,
    parameter int DIV     = DAC7611_DIV,
    parameter int GAP_CYC = DAC7611_GAP
) (
    input  logic              clk_X4,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              dac_sclk,
    output logic              dac_sdi,
    output logic              dac_ld,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    state_t            state_q;
    logic [DATA_W-1:0] sh_q;
    logic [BW-1:0]     bit_q;
    logic [GW-1:0]     gap_q;
    logic              half_q;
    logic              sclk_q, sdi_q, ld_q;
    logic              ready_q, busy_q, done_q;
    logic              tick, pre_tick;

    // Divider is held in reload while idle so SETUP starts a full period.
    dac_tick_div #(
        .DIV (DIV)
    ) u_div (
        .clk_X4     (clk_X4),
        .rst_n      (rst_n),
        .load_i     (state_q == IDLE),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    always_ff @(posedge clk_X4 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            half_q  <= 1'b0;
            sclk_q  <= SCLK_IDLE;
            sdi_q   <= 1'b0;
            ld_q    <= LD_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!enable) begin
            state_q <= IDLE;
            sclk_q  <= SCLK_IDLE;
            sdi_q   <= 1'b0;
            ld_q    <= LD_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (s_valid && ready_q) begin
                        sh_q    <= s_data;
                        sdi_q   <= s_data[DATA_W-1];
                        ld_q    <= 1'b1;
                        sclk_q  <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b0;
                        half_q  <= 1'b0;
                        bit_q   <= BW'(DATA_W);
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!half_q) begin
                            sclk_q <= 1'b1;
                            half_q <= 1'b1;
                        end else if (bit_q == BW'(1)) begin
                            // SCLK stays high into HOLD; a one-cycle HOLD
                            // needs done raised on entry.
                            state_q <= HOLD;
                            sdi_q   <= 1'b0;
                            done_q  <= pre_tick;
                        end else begin
                            bit_q  <= bit_q - BW'(1);
                            sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
                            sdi_q  <= sh_q[DATA_W-2];
                            sclk_q <= 1'b0;
                            half_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q <= GAP;
                        ld_q    <= LD_IDLE;
                        gap_q   <= GW'(GAP_CYC);
                    end else begin
                        done_q <= pre_tick;
                    end
                end
                GAP: begin
                    if (gap_q == GW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready  = ready_q;
    assign dac_sclk = sclk_q;
    assign dac_sdi  = sdi_q;
    assign dac_ld   = ld_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: default instance checked cycle by cycle against
// a frame-timeline model, plus a DATA_W=16/DIV=1/GAP=1 back-to-back instance.
module tb_dac_serial_tx;

    localparam int W  = 12;
    localparam int D  = 2;
    localparam int G  = 150;
    localparam int FR = 2 * D + 2 * D * W + G;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic          sv;
    logic [11:0]   sd;
    logic          rdy, sclk, sdi, ld, busy, done;

    logic          fv;
    logic [15:0]   fd;
    logic          frdy, fsclk, fsdi, fld, fbusy, fdone;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    dac_serial_tx u_def (
        .clk_X4   (clk),
        .rst_n    (rst_n),
        .enable   (en),
        .s_valid  (sv),
        .s_data   (sd),
        .s_ready  (rdy),
        .dac_sclk (sclk),
        .dac_sdi  (sdi),
        .dac_ld   (ld),
        .busy     (busy),
        .done     (done)
    );

    dac_serial_tx #(
        .DATA_W  (16),
        .DIV     (1),
        .GAP_CYC (1)
    ) u_fast (
        .clk_X4   (clk),
        .rst_n    (rst_n),
        .enable   (en),
        .s_valid  (fv),
        .s_data   (fd),
        .s_ready  (frdy),
        .dac_sclk (fsclk),
        .dac_sdi  (fsdi),
        .dac_ld   (fld),
        .busy     (fbusy),
        .done     (fdone)
    );

    // Expected {sclk,sdi,ld,busy,done,ready} k cycles after the accept edge.
    function automatic logic [5:0] exp_pins(input int k, input logic [11:0] w);
        int j, b;
        if (k <= D) return {1'b1, w[W-1], 4'b1100};
        if (k <= D + 2 * D * W) begin
            j = k - D - 1;
            b = W - 1 - j / (2 * D);
            return {((j % (2 * D)) >= D), w[b], 4'b1100};
        end
        if (k <= 2 * D + 2 * D * W)
            return {4'b1011, (k == 2 * D + 2 * D * W), 1'b0};
        if (k <= FR) return 6'b100100;
        return 6'b100001;
    endfunction

    task automatic accept_word(input logic [11:0] w, output bit ok);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy !== 1'b1) begin
            ncmp++; nfail++;
            $display("FAIL accept_timeout s_ready=%b want 1", rdy);
            ok = 1'b0;
            return;
        end
        sv = 1'b1;
        sd = w;
        @(posedge clk); #1;
        sv = 1'b0;
        sd = 12'($urandom);
        ok = 1'b1;
    endtask

    task automatic run_frame(input logic [11:0] w, input bit noise);
        bit ok, good;
        logic [5:0] e, a, fe, fa;
        int fk, dones;
        logic [11:0] cap, got;
        logic ps, pl;
        accept_word(w, ok);
        if (!ok) return;
        good = 1'b1; fk = 0; fe = '0; fa = '0;
        dones = 0; cap = '0; got = '0; ps = 1'b1; pl = 1'b0;
        for (int k = 1; k <= FR + 1; k++) begin
            a = {sclk, sdi, ld, busy, done, rdy};
            e = exp_pins(k, w);
            if (a !== e && good) begin
                good = 1'b0; fk = k; fe = e; fa = a;
            end
            if (ps == 1'b0 && sclk == 1'b1 && ld == 1'b1) cap = {cap[10:0], sdi};
            if (pl == 1'b1 && ld == 1'b0) got = cap;
            if (done === 1'b1) dones++;
            ps = sclk; pl = ld;
            if (k <= FR) begin
                sv = noise ? 1'($urandom) : 1'b0;
                sd = 12'($urandom);
                @(posedge clk); #1;
            end else begin
                sv = 1'b0;
            end
        end
        ncmp++;
        if (!good) begin
            nfail++;
            $display("FAIL frame_pins w=%h cycle %0d got %b want %b", w, fk, fa, fe);
        end
        ncmp++;
        if (got !== w) begin
            nfail++;
            $display("FAIL frame_capture got %h want %h", got, w);
        end
        ncmp++;
        if (dones !== 1) begin
            nfail++;
            $display("FAIL frame_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b1; sv = 1'b0; sd = '0; fv = 1'b0; fd = '0;
        repeat (3) @(posedge clk);
        #1;
        ncmp++;
        if ({sclk, sdi, ld, rdy, busy, done} !== 6'b100000) begin
            nfail++;
            $display("FAIL reset_def got %b want 100000", {sclk, sdi, ld, rdy, busy, done});
        end
        ncmp++;
        if ({fsclk, fsdi, fld, frdy, fbusy, fdone} !== 6'b100000) begin
            nfail++;
            $display("FAIL reset_fast got %b want 100000", {fsclk, fsdi, fld, frdy, fbusy, fdone});
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_800;
        run_frame(12'h800, 1'b0);
    endtask

    task automatic test_patterns;
        logic [11:0] w;
        run_frame(12'hA5C, 1'b0);
        run_frame(12'h000, 1'b0);
        run_frame(12'hFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w = 12'($urandom);
            run_frame(w, 1'b0);
        end
    endtask

    task automatic test_busy_noise;
        for (int i = 0; i < 2; i++) run_frame(12'($urandom), 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [15:0] w[4];
        logic [15:0] capq[$];
        logic [15:0] cap;
        int acc[4];
        int idx, viol;
        logic ps, pl;
        w[0] = 16'h1234; w[1] = 16'hFEDC;
        w[2] = 16'($urandom); w[3] = 16'($urandom);
        idx = 0; viol = 0; cap = '0;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        fd = w[0]; fv = 1'b1;
        ps = fsclk; pl = fld;
        for (int c = 0; c < 400 && capq.size() < 4; c++) begin
            if (ps == 1'b0 && fsclk == 1'b1 && fld == 1'b1) cap = {cap[14:0], fsdi};
            if (fsclk !== ps && fld == 1'b0 && pl == 1'b0) viol++;
            if (pl == 1'b1 && fld == 1'b0) capq.push_back(cap);
            ps = fsclk; pl = fld;
            if (fv && frdy === 1'b1) begin
                acc[idx] = c;
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) fd = w[idx];
            else fv = 1'b0;
        end
        fv = 1'b0;
        ncmp++;
        if (capq.size() != 4) begin
            nfail++;
            $display("FAIL b2b_count got %0d want 4", capq.size());
        end
        for (int i = 0; i < capq.size(); i++) begin
            ncmp++;
            if (capq[i] !== w[i]) begin
                nfail++;
                $display("FAIL b2b_word%0d got %h want %h", i, capq[i], w[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            ncmp++;
            if (acc[i] - acc[i-1] != 36) begin
                nfail++;
                $display("FAIL b2b_spacing%0d got %0d want 36", i, acc[i] - acc[i-1]);
            end
        end
        ncmp++;
        if (viol != 0) begin
            nfail++;
            $display("FAIL b2b_sclk_while_ld_low got %0d want 0", viol);
        end
    endtask

    task automatic test_abort;
        bit ok;
        int bad;
        accept_word(12'($urandom), ok);
        if (!ok) return;
        repeat (19) begin
            @(posedge clk); #1;
        end
        en = 1'b0;
        @(posedge clk); #1;
        ncmp++;
        if ({sclk, ld, busy, sdi, done} !== 5'b10000) begin
            nfail++;
            $display("FAIL abort_idle got %b want 10000", {sclk, ld, busy, sdi, done});
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) en = 1'b1;
            if (done !== 1'b0 || ld !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        ncmp++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL abort_no_done_ld got %0d want 0", bad);
        end
        run_frame(12'h123, 1'b0);
    endtask

    task automatic test_reset_mid;
        bit ok;
        accept_word(12'($urandom), ok);
        if (!ok) return;
        repeat (29) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if ({sclk, sdi, ld, rdy, busy, done} !== 6'b100000) begin
            nfail++;
            $display("FAIL async_reset got %b want 100000", {sclk, sdi, ld, rdy, busy, done});
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(12'h7FF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame_800();
        test_patterns();
        test_busy_noise();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
- Parametrised serial driver for DAC7611-class 3-wire DACs (SCLK, SDI, LD).
- Takes arbitrary DATA_W-bit words over a valid/ready handshake instead of a hard-coded code.
- Generates the complete shift-and-latch frame with programmable SCLK divider, setup/hold timing and inter-frame gap.
- Sits between the sample source (pattern generator / processor logic) and the DAC pins on the PL I/O bank.

Parameters:
- DATA_W, 12, bits per frame, shifted MSB first; legal 2..32.
- DIV, 2, clk_X4 cycles per SCLK half-period; legal >=1.
- GAP_CYC, 150, idle clk_X4 cycles after LD falls before the next word is accepted; legal >=1.

Ports:
- clk_X4  in  1  system clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  high enable; low aborts and holds idle.
- s_valid  in  1  word available.
- s_data  in  DATA_W  DAC code; sampled on accept.
- s_ready  out  1  block can accept a word.
- dac_sclk  out  1  DAC CLK pin; idles high.
- dac_sdi  out  1  DAC SDI pin.
- dac_ld  out  1  DAC LD pin; high while shifting, low latches the word.
- busy  out  1  frame in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when a frame completes (end of HOLD).

Behaviour:
- Reset values (async, rst_n=0): state=IDLE; dac_sclk=1, dac_sdi=0, dac_ld=0, s_ready=0, busy=0, done=0. All outputs are registered.
- IDLE:
  - s_ready=enable.
  - Accept on the edge where s_valid & s_ready & enable; latch s_data into the shift register; go to SETUP.
  - s_ready drops the cycle after accept.
- SETUP (DIV cycles): dac_ld=1, dac_sclk=1, dac_sdi=MSB.
- SHIFT (DATA_W bits, 2*DIV cycles each):
  - The first DIV cycles of each bit have dac_sclk=0; the next DIV cycles have dac_sclk=1.
  - dac_sdi changes only at bit start, coincident with the SCLK falling edge, and is stable across the rising edge where the DAC samples.
  - Bit order is MSB to LSB.
- HOLD (DIV cycles): dac_ld=1, dac_sclk=1, dac_sdi=0. On its last cycle, done pulses and the next state is GAP.
- GAP (GAP_CYC cycles): dac_ld=0, which latches the word into the DAC; dac_sclk=1; s_ready=0. Then go to IDLE.
- Frame length, accept edge to IDLE: DIV + 2*DIV*DATA_W + DIV + GAP_CYC cycles. Defaults give 202 cycles.
- Minimum accept-to-accept spacing is frame length + 1 cycle.
- enable low in any state: next edge goes to IDLE with idle outputs (sclk=1, ld=0, sdi=0). No done pulse. The partially shifted word is discarded; LD never falls after a partial frame while enabled.
- rst_n asserted mid-frame: outputs reach reset values immediately (asynchronous). The frame is lost.
- s_valid while busy: ignored, because s_ready=0. The source must hold s_valid until accepted.
- s_data changes after accept have no effect on the frame in flight.
- Counters:
  - Divider counter width $clog2(DIV+1).
  - Bit counter width $clog2(DATA_W+1).
  - Gap counter width $clog2(GAP_CYC+1).
  - Counters never wrap; each is reloaded at state entry.

Decomposition:
- Package dac_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, GAP};
  - default constants DAC7611_DATA_W=12, DAC7611_DIV=2, DAC7611_GAP=150;
  - idle pin levels SCLK_IDLE=1, LD_IDLE=0.
- Sub-module dac_tick_div: down-counter producing a one-cycle tick every DIV cycles, restartable by a load pulse. The FSM uses it for SETUP, SHIFT half-periods and HOLD.

Test Plan:
- Defaults, s_data=12'h800 held valid -> ld rises 1 cycle after accept; sdi=1 for bit 11 then 0 for bits 10..0; 12 sclk low pulses of 2 cycles each; ld low at cycle 53 after accept; done pulse at cycle 52; s_ready returns at cycle 203.
- Defaults, s_data=12'hA5C, with a bench shift register sampling sdi on each sclk rise -> captured 12'hA5C on the ld falling edge; repeat for 12'h000 and 12'hFFF.
- DATA_W=16, DIV=1, GAP_CYC=1, back-to-back words 16'h1234 then 16'hFEDC with s_valid always high -> both captured in order; accept spacing 36 cycles; no sclk edges while ld=0.
- Defaults: deassert enable at cycle 20 of a frame -> next edge sclk=1, ld=0, busy=0; no done; re-enable and send 12'h123 -> clean full frame captured as 12'h123.
- Defaults: pulse rst_n low mid-SHIFT -> outputs at reset values within the same cycle (asynchronous); after release, a fresh word 12'h7FF transmits correctly.
- Defaults: s_valid toggled and s_data changed while busy -> no extra accepts, in-flight word unchanged, done count equals accept count.
